// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter sequencing controller.
package pc_ctrl_pkg;

  // Controller state encoding; the values are visible on o_state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              clear,
  input  logic              inc,
  output logic [NB_CNT-1:0] count
);

  logic [NB_CNT-1:0] r_count;

  // Count register: async reset, synchronous clear, saturating increment.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + NB_CNT'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: sequences load / run / single-step / halt and
// computes the next-PC value and write enable for the external PC register.
//
// state | meaning
// IDLE  | waiting for load, run or step
// RUN   | advancing every non-stalled cycle until halt
// STEP  | one advance pending; held here while stalled
// DONE  | HALT instruction reached; only a load leaves
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int NB_PC  = 32,
  parameter int NB_CNT = 32
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_load_valid,
  input  logic [NB_PC-1:0]  i_load_addr,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic              i_stall,
  input  logic              i_halt_instr,
  input  logic              i_branch_taken,
  input  logic [NB_PC-1:0]  i_branch_target,
  input  logic              i_jump,
  input  logic [NB_PC-1:0]  i_jump_target,
  input  logic [NB_PC-1:0]  i_pc,
  output logic [NB_PC-1:0]  o_pc_next,
  output logic              o_pc_en,
  output logic [1:0]        o_state,
  output logic              o_done,
  output logic [NB_CNT-1:0] o_cycle_cnt
);

  state_e            r_state;
  state_e            w_state_next;
  logic              w_load;
  logic              w_busy;
  logic              w_adv;
  logic [NB_PC-1:0]  w_pc_inc;

  // Load is only honoured when no operation is in flight.
  assign w_load   = i_load_valid && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_busy   = (r_state == ST_RUN) || (r_state == ST_STEP);
  // halt_req only blocks an advance in RUN; a step in progress ignores it.
  assign w_adv    = w_busy && !i_stall && !i_halt_instr &&
                    !((r_state == ST_RUN) && i_halt_req);
  assign w_pc_inc = i_pc + NB_PC'(PC_INC);

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load_valid)  w_state_next = ST_IDLE;
        else if (i_run)    w_state_next = ST_RUN;
        else if (i_step)   w_state_next = ST_STEP;
      end
      ST_RUN: begin
        if (i_halt_instr)    w_state_next = ST_DONE;
        else if (i_halt_req) w_state_next = ST_IDLE;
      end
      ST_STEP: begin
        if (i_halt_instr) w_state_next = ST_DONE;
        else if (w_adv)   w_state_next = ST_IDLE;
      end
      ST_DONE: begin
        if (i_load_valid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs: next-PC selection and enable, all forced to zero while in reset.
  always_comb begin
    o_pc_en   = 1'b0;
    o_pc_next = '0;
    if (i_rst_n) begin
      o_pc_next = w_pc_inc;
      if (w_load) begin
        o_pc_en   = 1'b1;
        o_pc_next = i_load_addr;
      end else if (w_adv) begin
        o_pc_en = 1'b1;
        if (i_branch_taken) o_pc_next = i_branch_target;
        else if (i_jump)    o_pc_next = i_jump_target;
      end
    end
  end

  assign o_state = r_state;
  assign o_done  = i_rst_n && (r_state == ST_DONE);

  // Cycles spent executing since the last load.
  sat_counter #(
    .NB_CNT(NB_CNT)
  ) u_cycle_cnt (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .clear  (w_load),
    .inc    (w_busy),
    .count  (o_cycle_cnt)
  );

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a driver pushes expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_pc_ctrl;

  localparam int NB_PC   = 32;
  localparam int NB_CNT  = 4;
  localparam int CNT_MAX = 15;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_STEP = 2'd2;
  localparam logic [1:0] M_DONE = 2'd3;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_load_valid;
  logic [NB_PC-1:0]  i_load_addr;
  logic              i_run;
  logic              i_step;
  logic              i_halt_req;
  logic              i_stall;
  logic              i_halt_instr;
  logic              i_branch_taken;
  logic [NB_PC-1:0]  i_branch_target;
  logic              i_jump;
  logic [NB_PC-1:0]  i_jump_target;
  logic [NB_PC-1:0]  i_pc;
  logic [NB_PC-1:0]  o_pc_next;
  logic              o_pc_en;
  logic [1:0]        o_state;
  logic              o_done;
  logic [NB_CNT-1:0] o_cycle_cnt;

  pc_ctrl #(.NB_PC(NB_PC), .NB_CNT(NB_CNT)) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .i_load_valid   (i_load_valid),
    .i_load_addr    (i_load_addr),
    .i_run          (i_run),
    .i_step         (i_step),
    .i_halt_req     (i_halt_req),
    .i_stall        (i_stall),
    .i_halt_instr   (i_halt_instr),
    .i_branch_taken (i_branch_taken),
    .i_branch_target(i_branch_target),
    .i_jump         (i_jump),
    .i_jump_target  (i_jump_target),
    .i_pc           (i_pc),
    .o_pc_next      (o_pc_next),
    .o_pc_en        (o_pc_en),
    .o_state        (o_state),
    .o_done         (o_done),
    .o_cycle_cnt    (o_cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [31:0] nxt;
    logic [1:0]  st;
    logic        done;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: operating mode, executed-cycle count, and the PC register
  // that the DUT's outputs would drive.
  logic [1:0]  m_mode;
  int          m_cnt;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("pc_en",   32'(o_pc_en),     32'(e_mon.en));
      chk("pc_next", o_pc_next,        e_mon.nxt);
      chk("state",   32'(o_state),     32'(e_mon.st));
      chk("done",    32'(o_done),      32'(e_mon.done));
      chk("cycle_cnt", 32'(o_cycle_cnt), 32'(e_mon.cnt));
    end
  end

  task automatic idle_in();
    i_load_valid = 0; i_load_addr = '0; i_run = 0; i_step = 0; i_halt_req = 0;
    i_stall = 0; i_halt_instr = 0; i_branch_taken = 0; i_jump = 0;
    i_branch_target = '0; i_jump_target = '0;
  endtask

  // Present current inputs for one cycle, predict the response, advance the model.
  task automatic step_cycle();
    logic load_ok, busy, adv, en;
    logic [31:0] nxt;
    logic [1:0]  nm;
    int          nc;
    exp_t        e;
    i_pc    = m_pc;
    load_ok = i_load_valid && (m_mode == M_IDLE || m_mode == M_DONE);
    busy    = (m_mode == M_RUN) || (m_mode == M_STEP);
    adv     = busy && !i_stall && !i_halt_instr && !(m_mode == M_RUN && i_halt_req);
    en      = load_ok || adv;
    if (load_ok)                  nxt = i_load_addr;
    else if (adv && i_branch_taken) nxt = i_branch_target;
    else if (adv && i_jump)       nxt = i_jump_target;
    else                          nxt = m_pc + 32'd4;
    nm = m_mode;
    if (m_mode == M_IDLE) begin
      if (i_load_valid) nm = M_IDLE;
      else if (i_run)   nm = M_RUN;
      else if (i_step)  nm = M_STEP;
    end else if (m_mode == M_RUN) begin
      if (i_halt_instr)    nm = M_DONE;
      else if (i_halt_req) nm = M_IDLE;
    end else if (m_mode == M_STEP) begin
      if (i_halt_instr) nm = M_DONE;
      else if (adv)     nm = M_IDLE;
    end else begin
      if (i_load_valid) nm = M_IDLE;
    end
    if (load_ok)   nc = 0;
    else if (busy) nc = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    else           nc = m_cnt;
    e.en = en; e.nxt = nxt; e.st = m_mode; e.done = (m_mode == M_DONE); e.cnt = 4'(m_cnt);
    q.push_back(e);
    @(posedge clk);
    m_mode = nm;
    m_cnt  = nc;
    if (en) m_pc = nxt;
    #1;
  endtask

  task automatic do_load(input logic [31:0] a);
    idle_in(); i_load_valid = 1; i_load_addr = a; step_cycle(); idle_in();
  endtask

  task automatic pulse_run();
    idle_in(); i_run = 1; step_cycle(); idle_in();
  endtask

  // Assert reset between edges and check outputs respond without a clock.
  task automatic mid_reset(input string tag);
    idle_in();
    #2 i_rst_n = 0;
    #1;
    chk({tag, "_rst_pc_en"},   32'(o_pc_en),     32'd0);
    chk({tag, "_rst_pc_next"}, o_pc_next,        32'd0);
    chk({tag, "_rst_state"},   32'(o_state),     32'd0);
    chk({tag, "_rst_done"},    32'(o_done),      32'd0);
    chk({tag, "_rst_cnt"},     32'(o_cycle_cnt), 32'd0);
    @(posedge clk);
    #2 i_rst_n = 1;
    m_mode = M_IDLE; m_cnt = 0; m_pc = 32'h0;
    step_cycle();
    step_cycle();
  endtask

  initial begin
    idle_in();
    i_pc = 32'h1234;
    i_rst_n = 0;
    m_mode = M_IDLE; m_cnt = 0; m_pc = 32'h0;
    #3;
    chk("init_pc_en",   32'(o_pc_en),     32'd0);
    chk("init_pc_next", o_pc_next,        32'd0);
    chk("init_state",   32'(o_state),     32'd0);
    chk("init_done",    32'(o_done),      32'd0);
    chk("init_cnt",     32'(o_cycle_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2 i_rst_n = 1;

    // Load then single step.
    do_load(32'h100);
    i_step = 1; step_cycle(); idle_in();
    step_cycle();
    step_cycle();
    chk("step_final_cnt", 32'(o_cycle_cnt), 32'd1);

    // Branch beats jump in the same cycle.
    do_load(32'h0);
    pulse_run();
    i_branch_taken = 1; i_branch_target = 32'h40; i_jump = 1; i_jump_target = 32'h80;
    step_cycle();
    idle_in(); i_jump = 1; i_jump_target = 32'h80; step_cycle();
    idle_in(); i_halt_req = 1; step_cycle(); idle_in();

    // Step held off by three stall cycles.
    do_load(32'h200);
    i_step = 1; step_cycle(); idle_in();
    i_stall = 1; repeat (3) step_cycle();
    i_stall = 0; step_cycle();
    step_cycle();
    chk("stall_step_cnt", 32'(o_cycle_cnt), 32'd4);

    // Halt instr and halt req together, DONE ignores run/step, load exits.
    do_load(32'h300);
    pulse_run();
    step_cycle();
    i_halt_instr = 1; i_halt_req = 1; step_cycle(); idle_in();
    step_cycle();
    i_run = 1; step_cycle(); idle_in();
    i_step = 1; step_cycle(); idle_in();
    do_load(32'h0);
    step_cycle();

    // Counter saturation and PC wrap.
    do_load(32'h0);
    pulse_run();
    repeat (20) step_cycle();
    m_pc = 32'hFFFF_FFFC;
    step_cycle();
    i_halt_req = 1; step_cycle(); idle_in();

    // Reset mid-RUN and mid-STEP.
    do_load(32'h500);
    pulse_run();
    step_cycle();
    mid_reset("run");
    do_load(32'h600);
    i_step = 1; step_cycle(); idle_in();
    i_stall = 1; step_cycle();
    mid_reset("step");

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      i_load_valid    = ($urandom_range(0, 9) == 0);
      i_load_addr     = $urandom;
      i_run           = ($urandom_range(0, 5) == 0);
      i_step          = ($urandom_range(0, 5) == 0);
      i_halt_req      = ($urandom_range(0, 9) == 0);
      i_stall         = ($urandom_range(0, 3) == 0);
      i_halt_instr    = ($urandom_range(0, 14) == 0);
      i_branch_taken  = ($urandom_range(0, 2) == 0);
      i_branch_target = $urandom;
      i_jump          = ($urandom_range(0, 2) == 0);
      i_jump_target   = $urandom;
      step_cycle();
    end
    idle_in();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter NB_PC, default 32, width of the program counter and all address ports.
REQ-002 Parameter NB_CNT, default 32, width of the executed-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_load_valid  in  1  load-start-address request.
REQ-006 i_load_addr  in  NB_PC  start address accepted with i_load_valid.
REQ-007 i_run  in  1  start continuous execution.
REQ-008 i_step  in  1  execute one instruction.
REQ-009 i_halt_req  in  1  stop continuous execution.
REQ-010 i_stall  in  1  hazard-unit stall; blocks PC advance.
REQ-011 i_halt_instr  in  1  HALT instruction present at current PC.
REQ-012 i_branch_taken  in  1  branch resolved taken.
REQ-013 i_branch_target  in  NB_PC  branch destination.
REQ-014 i_jump  in  1  jump decoded.
REQ-015 i_jump_target  in  NB_PC  jump destination.
REQ-016 i_pc  in  NB_PC  current PC register value.
REQ-017 o_pc_next  out  NB_PC  next-PC value driven to the PC register input.
REQ-018 o_pc_en  out  1  PC register write enable.
REQ-019 o_state  out  2  current controller state encoding.
REQ-020 o_done  out  1  high while in DONE.
REQ-021 o_cycle_cnt  out  NB_CNT  cycles spent in RUN or STEP since the last load.

Function
REQ-022 The FSM SHALL have four states: IDLE=0, RUN=1, STEP=2, DONE=3, registered.
REQ-023 IDLE: i_load_valid SHALL take priority over i_run, and i_run over i_step; a load keeps IDLE, i_run goes to RUN, i_step goes to STEP.
REQ-024 A load SHALL assert o_pc_en with o_pc_next=i_load_addr in that cycle and clear o_cycle_cnt to 0.
REQ-025 i_load_valid SHALL be accepted only in IDLE and DONE; in RUN and STEP it is ignored.
REQ-026 "Advance" is defined as: state RUN or STEP, i_stall=0, i_halt_instr=0, and (in RUN) i_halt_req=0.
REQ-027 On advance, o_pc_en=1; o_pc_next SHALL be i_branch_target if i_branch_taken, else i_jump_target if i_jump, else i_pc+4 (modulo 2^NB_PC, wrap-around permitted).
REQ-028 When no advance or load occurs, o_pc_en=0; o_pc_next SHALL equal i_pc+4 (don't-care for the PC, but fixed for checking).
REQ-029 o_pc_next and o_pc_en SHALL be combinational from the registered state and the current inputs, with zero-cycle latency.
REQ-030 RUN: i_halt_instr=1 SHALL go to DONE, else i_halt_req=1 SHALL go to IDLE, else stay RUN; i_halt_instr wins over i_halt_req when both are asserted.
REQ-031 STEP: one advance SHALL return to IDLE; while i_stall=1 the block stays in STEP, so the step completes only on an actual PC write; i_halt_instr=1 SHALL go to DONE without advance.
REQ-032 DONE: o_done=1; i_run and i_step are ignored; i_load_valid SHALL perform a load and go to IDLE.
REQ-033 o_cycle_cnt SHALL increment by 1 every cycle the state is RUN or STEP, stalls included, and saturate at all-ones.
REQ-034 i_run, i_step and i_halt_req are single-cycle pulses; a pulse held longer is re-evaluated each cycle per the rules above.

Reset
REQ-035 While i_rst_n=0: state IDLE, o_cycle_cnt=0, o_done=0, o_pc_en=0, o_pc_next=0, all forced immediately without waiting for a clock edge.
REQ-036 Reset asserted mid-RUN or mid-STEP SHALL abort the operation; after release the block is in IDLE with no pending step.

Structure
REQ-037 Package pc_ctrl_pkg SHALL hold the state encodings and the PC increment constant (4).
REQ-038 The saturating cycle counter SHALL be a sub-module sat_counter (ports: clear, inc, count), parameterised by NB_CNT.

Verification
REQ-039 Load 0x100 in IDLE, then i_step with no stall -> o_pc_en pulses once with o_pc_next=0x104, state returns to IDLE, o_cycle_cnt=1.
REQ-040 i_run at PC 0x0, i_branch_taken=1 with target 0x40 in the same cycle as i_jump=1 with target 0x80 -> o_pc_next=0x40.
REQ-041 i_step while i_stall=1 for 3 cycles, then released -> o_pc_en stays 0 for 3 cycles, pulses in the 4th, then IDLE; o_cycle_cnt=4.
REQ-042 In RUN, i_halt_instr and i_halt_req asserted together -> DONE, o_done=1, no PC write; a later i_run is ignored; load 0x0 -> IDLE, count 0.
REQ-043 NB_CNT=4 in RUN for 20 cycles -> o_cycle_cnt saturates at 15; i_pc=0xFFFFFFFC advances -> o_pc_next=0x0.
REQ-044 i_rst_n driven low between clock edges mid-RUN -> outputs reach reset values before the next edge; after release, state is IDLE.
